// File: rtl/uart_pkg.sv
// Shared UART definitions: receive/transmit FSM state encoding and bit-timing helpers.
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_t;

    function automatic int bit_cycles(input int clock_freq, input int baud_rate);
        return clock_freq / baud_rate;
    endfunction

    function automatic int mid_cycles(input int clock_freq, input int baud_rate);
        return bit_cycles(clock_freq, baud_rate) / 2;
    endfunction

endpackage

// File: rtl/uart_rx_buffered_if.sv
// Receive-side byte stream (valid/ready) plus the two one-cycle error pulses.
interface uart_rx_buffered_if;
    logic [7:0] data_out;
    logic       data_out_valid;
    logic       data_out_ready;
    logic       framing_error;
    logic       overrun;

    modport master (
        output data_out,
        output data_out_valid,
        output framing_error,
        output overrun,
        input  data_out_ready
    );

    modport slave (
        input  data_out,
        input  data_out_valid,
        input  framing_error,
        input  overrun,
        output data_out_ready
    );
endinterface

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO; head word is visible combinationally, zero when empty.
// A push on a full FIFO is accepted only if a pop frees a slot in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       pop_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      cnt;
    logic             do_push;
    logic             do_pop;

    assign empty    = (cnt == '0);
    assign full     = (cnt == (AW+1)'(DEPTH));
    assign count    = cnt;
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/uart_rx_buffered.sv
// 8N1 UART receiver feeding a small FIFO; a byte is visible the cycle after its stop sample.
// Bytes arriving while the FIFO is full (and not being popped) are dropped with an overrun pulse.
module uart_rx_buffered
    import uart_pkg::*;
#(
    parameter int CLOCK_FREQ = 125_000_000,
    parameter int BAUD_RATE  = 115_200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                serial_in,
    uart_rx_buffered_if.master  rx
);
    localparam int CYCLES = bit_cycles(CLOCK_FREQ, BAUD_RATE);
    localparam int MID    = mid_cycles(CLOCK_FREQ, BAUD_RATE);
    localparam int CW     = $clog2(CYCLES);
    localparam logic [CW-1:0] BIT_LAST = CW'(CYCLES - 1);
    localparam logic [CW-1:0] MID_LAST = CW'(MID - 1);

    logic                        sync_meta;
    logic                        line;
    uart_state_t                 state;
    logic [CW-1:0]               cnt;
    logic [2:0]                  bit_idx;
    logic [7:0]                  shreg;
    logic                        framing_error_q;
    logic                        overrun_q;
    logic                        stop_tick;
    logic                        push;
    logic                        pop;
    logic                        fifo_full;
    logic                        fifo_empty;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_meta <= 1'b1;
            line      <= 1'b1;
        end else begin
            sync_meta <= serial_in;
            line      <= sync_meta;
        end
    end

    assign stop_tick = (state == ST_STOP) && (cnt == BIT_LAST);
    assign push      = stop_tick && line;
    assign pop       = !fifo_empty && rx.data_out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= ST_IDLE;
            cnt             <= '0;
            bit_idx         <= '0;
            shreg           <= '0;
            framing_error_q <= 1'b0;
            overrun_q       <= 1'b0;
        end else begin
            framing_error_q <= 1'b0;
            overrun_q       <= 1'b0;
            case (state)
                ST_IDLE: begin
                    cnt     <= '0;
                    bit_idx <= '0;
                    if (!line) begin
                        state <= ST_START;
                    end
                end
                ST_START: begin
                    if (cnt == MID_LAST) begin
                        cnt   <= '0;
                        state <= line ? ST_IDLE : ST_DATA;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ST_DATA: begin
                    if (cnt == BIT_LAST) begin
                        cnt     <= '0;
                        shreg   <= {line, shreg[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            state <= ST_STOP;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ST_STOP: begin
                    // Back to IDLE on the stop sample itself so the next start bit is not missed.
                    if (cnt == BIT_LAST) begin
                        cnt   <= '0;
                        state <= ST_IDLE;
                        if (!line) begin
                            framing_error_q <= 1'b1;
                        end else if (fifo_full && !pop) begin
                            overrun_q <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (shreg),
        .pop       (pop),
        .pop_data  (rx.data_out),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign rx.data_out_valid = (fifo_count != '0);
    assign rx.framing_error  = framing_error_q;
    assign rx.overrun        = overrun_q;
endmodule

// File: tb/tb_uart_rx_buffered.sv
// Directed bench for uart_rx_buffered at 50 MHz / 1 Mbaud (50 clocks per bit).
module tb_uart_rx_buffered;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic serial_in = 1'b1;

    uart_rx_buffered_if rx_if ();

    uart_rx_buffered #(
        .CLOCK_FREQ (50_000_000),
        .BAUD_RATE  (1_000_000),
        .FIFO_DEPTH (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .serial_in (serial_in),
        .rx        (rx_if)
    );

    always #10 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [7:0] rx_q [$];
    int fe_cnt = 0;
    int ov_cnt = 0;

    // Collects accepted bytes and error pulses; runs just after each falling edge.
    always @(negedge clk) begin
        #1;
        if (!rst) begin
            if (rx_if.data_out_valid && rx_if.data_out_ready) rx_q.push_back(rx_if.data_out);
            if (rx_if.framing_error) fe_cnt++;
            if (rx_if.overrun) ov_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        serial_in = 1'b0;
        repeat (50) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            serial_in = b[i];
            repeat (50) @(negedge clk);
        end
        serial_in = stop_bit;
        repeat (50) @(negedge clk);
        serial_in = 1'b1;
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int base;
        int fe0;
        int ov0;

        rx_if.data_out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_valid", rx_if.data_out_valid, 0);
        check("rst_data", rx_if.data_out, 0);
        check("rst_fe", rx_if.framing_error, 0);
        check("rst_ov", rx_if.overrun, 0);
        rst = 1'b0;
        repeat (10) @(negedge clk);

        // Single byte: one-cycle valid pulse within 480 cycles of the start edge
        fe0 = fe_cnt; ov0 = ov_cnt;
        fork
            send_frame(8'h61, 1'b1);
            begin
                n = 0;
                while (!rx_if.data_out_valid && n < 480) begin
                    @(negedge clk);
                    n++;
                end
                check("t1_valid", rx_if.data_out_valid, 1);
                check("t1_data", rx_if.data_out, 8'h61);
                @(negedge clk);
                check("t1_pulse_end", rx_if.data_out_valid, 0);
            end
        join
        repeat (5) @(negedge clk);
        check("t1_fe", fe_cnt - fe0, 0);
        check("t1_ov", ov_cnt - ov0, 0);

        // Ten back-to-back frames
        base = rx_q.size(); fe0 = fe_cnt; ov0 = ov_cnt;
        for (int i = 0; i < 10; i++) send_frame(8'h61 + 8'(i), 1'b1);
        repeat (10) @(negedge clk);
        check("t2_count", rx_q.size() - base, 10);
        for (int i = 0; i < 10; i++) begin
            if (base + i < rx_q.size()) check("t2_byte", rx_q[base + i], 8'h61 + 8'(i));
        end
        check("t2_fe", fe_cnt - fe0, 0);
        check("t2_ov", ov_cnt - ov0, 0);

        // Short low glitch, then a real frame
        base = rx_q.size(); fe0 = fe_cnt; ov0 = ov_cnt;
        serial_in = 1'b0;
        repeat (10) @(negedge clk);
        serial_in = 1'b1;
        repeat (100) @(negedge clk);
        check("t3_glitch_bytes", rx_q.size() - base, 0);
        check("t3_glitch_valid", rx_if.data_out_valid, 0);
        check("t3_glitch_fe", fe_cnt - fe0, 0);
        check("t3_glitch_ov", ov_cnt - ov0, 0);
        send_frame(8'h41, 1'b1);
        repeat (10) @(negedge clk);
        check("t3_count", rx_q.size() - base, 1);
        if (rx_q.size() > base) check("t3_byte", rx_q[base], 8'h41);

        // Bad stop bit, then a good frame
        base = rx_q.size(); fe0 = fe_cnt;
        send_frame(8'h55, 1'b0);
        repeat (60) @(negedge clk);
        check("t4_fe", fe_cnt - fe0, 1);
        check("t4_bytes", rx_q.size() - base, 0);
        check("t4_valid", rx_if.data_out_valid, 0);
        send_frame(8'h56, 1'b1);
        repeat (10) @(negedge clk);
        check("t4_count", rx_q.size() - base, 1);
        if (rx_q.size() > base) check("t4_byte", rx_q[base], 8'h56);
        check("t4_fe_once", fe_cnt - fe0, 1);

        // Overrun with the consumer stalled
        rx_if.data_out_ready = 1'b0;
        base = rx_q.size(); ov0 = ov_cnt;
        for (int i = 0; i < 4; i++) send_frame(8'h61 + 8'(i), 1'b1);
        repeat (5) @(negedge clk);
        check("t5_ov_before", ov_cnt - ov0, 0);
        check("t5_valid_full", rx_if.data_out_valid, 1);
        check("t5_head", rx_if.data_out, 8'h61);
        send_frame(8'h65, 1'b1);
        repeat (5) @(negedge clk);
        check("t5_ov_after", ov_cnt - ov0, 1);
        check("t5_head_stable", rx_if.data_out, 8'h61);
        rx_if.data_out_ready = 1'b1;
        repeat (8) @(negedge clk);
        check("t5_count", rx_q.size() - base, 4);
        for (int i = 0; i < 4; i++) begin
            if (base + i < rx_q.size()) check("t5_byte", rx_q[base + i], 8'h61 + 8'(i));
        end
        check("t5_empty", rx_if.data_out_valid, 0);

        // Reset mid-frame discards buffered and partial bytes
        rx_if.data_out_ready = 1'b0;
        send_frame(8'h11, 1'b1);
        repeat (5) @(negedge clk);
        check("t6_buffered", rx_if.data_out_valid, 1);
        fork
            send_frame(8'hA5, 1'b1);
            begin
                repeat (270) @(negedge clk);
                rst = 1'b1;
                #1;
                check("t6_rst_valid", rx_if.data_out_valid, 0);
                check("t6_rst_data", rx_if.data_out, 0);
                check("t6_rst_fe", rx_if.framing_error, 0);
                check("t6_rst_ov", rx_if.overrun, 0);
                repeat (100) @(negedge clk);
                check("t6_rst_valid_hold", rx_if.data_out_valid, 0);
            end
        join
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check("t6_post_rst_valid", rx_if.data_out_valid, 0);
        rx_if.data_out_ready = 1'b1;
        base = rx_q.size();
        send_frame(8'h3C, 1'b1);
        repeat (10) @(negedge clk);
        check("t6_count", rx_q.size() - base, 1);
        if (rx_q.size() > base) check("t6_byte", rx_q[base], 8'h3C);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
